// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the regfile_mp register bank and its clear sequencer.
package regfile_pkg;

   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_ADDR_W = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } clr_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: walks ptr over every entry, one per cycle, and
// reports progress through registered clr_busy / clr_done flags.
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LAST = '1;

   clr_state_e        state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic              busy_q;
   logic              done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (clr_req) begin
                  state_q <= CLEAR;
                  ptr_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            CLEAR: begin
               // ptr parks on the last entry instead of wrapping
               if (ptr_q == LAST) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  ptr_q <= ptr_q + 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_busy = busy_q;
   assign clr_done = done_q;
   assign clr_we   = busy_q;
   assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised 2-read/1-write register file with optional zero register and bulk clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] reg_to_write,
   input  logic [DATA_W-1:0] data_to_write,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              ext_we;
   logic              zero_rs;
   logic              zero_rt;
   logic              zero_wr;

   regfile_clear_fsm #(
      .ADDR_W (ADDR_W)
   ) u_clear_fsm (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_done (clr_done),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign zero_rs = (ZERO_REG != 0) && (rs == '0);
   assign zero_rt = (ZERO_REG != 0) && (rt == '0);
   assign zero_wr = (ZERO_REG != 0) && (reg_to_write == '0);
   assign ext_we  = reg_write && !clr_busy && !zero_wr;

   // The clear engine owns the write port while busy, so the two writers never collide.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (clr_we) begin
         mem_q[clr_addr] <= '0;
      end else if (ext_we) begin
         mem_q[reg_to_write] <= data_to_write;
      end
   end

   always_comb begin
      rd1 = mem_q[rs];
      rd2 = mem_q[rt];
`ifdef REGFILE_BYPASS_EN
      if (ext_we && (reg_to_write == rs)) rd1 = data_to_write;
      if (ext_we && (reg_to_write == rt)) rd2 = data_to_write;
`endif
      if (zero_rs) rd1 = '0;
      if (zero_rt) rd2 = '0;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default 32x32, ZERO_REG=1).
module tb_regfile_mp;

   logic        clk;
   logic        rst;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic        reg_write;
   logic [4:0]  reg_to_write;
   logic [31:0] data_to_write;
   logic        clr_req;
   logic        clr_busy;
   logic        clr_done;

   int errors = 0;
   int checks = 0;

   regfile_mp dut (
      .clk           (clk),
      .rst           (rst),
      .rs            (rs),
      .rt            (rt),
      .rd1           (rd1),
      .rd2           (rd2),
      .reg_write     (reg_write),
      .reg_to_write  (reg_to_write),
      .data_to_write (data_to_write),
      .clr_req       (clr_req),
      .clr_busy      (clr_busy),
      .clr_done      (clr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_all();
      for (int i = 0; i < 32; i++) begin
         reg_write     = 1'b1;
         reg_to_write  = 5'(i);
         data_to_write = 32'(i + 1);
         step();
      end
      reg_write = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      rs  = 5'd5;
      rt  = 5'd31;
      #1;
      checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got=%h exp=%h", rd1, 32'h0); end
      checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL reset_rd2 got=%h exp=%h", rd2, 32'h0); end
      checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", clr_busy); end
      checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", clr_done); end
   endtask

   task automatic test_write_read();
      reg_write     = 1'b1;
      reg_to_write  = 5'd7;
      data_to_write = 32'hDEADBEEF;
      step();
      reg_write = 1'b0;
      rs = 5'd7;
      rt = 5'd7;
      #1;
      checks++; if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_r7_rd1 got=%h exp=%h", rd1, 32'hDEADBEEF); end
      checks++; if (rd2 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_r7_rd2 got=%h exp=%h", rd2, 32'hDEADBEEF); end
      reg_write     = 1'b1;
      reg_to_write  = 5'd0;
      data_to_write = 32'h1234;
      step();
      reg_write = 1'b0;
      rs = 5'd0;
      #1;
      checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL wr_r0_rd1 got=%h exp=%h", rd1, 32'h0); end
   endtask

   task automatic test_bypass();
      logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
      exp_same = 32'hA5A5A5A5;
`else
      exp_same = 32'h0;
`endif
      reg_write     = 1'b1;
      reg_to_write  = 5'd3;
      data_to_write = 32'hA5A5A5A5;
      rs = 5'd3;
      rt = 5'd7;
      #1;
      checks++; if (rd1 !== exp_same) begin errors++; $display("FAIL bypass_same_cycle got=%h exp=%h", rd1, exp_same); end
      checks++; if (rd2 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_other_port got=%h exp=%h", rd2, 32'hDEADBEEF); end
      step();
      reg_write = 1'b0;
      #1;
      checks++; if (rd1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_next_cycle got=%h exp=%h", rd1, 32'hA5A5A5A5); end
      reg_write     = 1'b1;
      reg_to_write  = 5'd0;
      data_to_write = 32'hFFFF0000;
      rs = 5'd0;
      #1;
      checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL bypass_zero_reg got=%h exp=%h", rd1, 32'h0); end
      step();
      reg_write = 1'b0;
   endtask

   task automatic test_bulk_clear();
      int busy_cnt  = 0;
      int done_cnt  = 0;
      int done_cyc  = 0;
      logic busy_at_done = 1'b1;
      int nz = 0;
      fill_all();
      rs = 5'd31;
      rt = 5'd9;
      #1;
      checks++; if (rd1 !== 32'd32) begin errors++; $display("FAIL fill_r31 got=%h exp=%h", rd1, 32'd32); end
      checks++; if (rd2 !== 32'd10) begin errors++; $display("FAIL fill_r9 got=%h exp=%h", rd2, 32'd10); end
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         reg_write     = (c <= 32);
         reg_to_write  = 5'd9;
         data_to_write = 32'h99;
         #1;
         if (clr_busy === 1'b1) busy_cnt++;
         if (clr_done === 1'b1) begin
            done_cnt++;
            done_cyc     = c;
            busy_at_done = clr_busy;
         end
         step();
      end
      reg_write = 1'b0;
      checks++; if (busy_cnt != 32) begin errors++; $display("FAIL clr_busy_len got=%0d exp=32", busy_cnt); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL clr_done_pulses got=%0d exp=1", done_cnt); end
      checks++; if (done_cyc != 33) begin errors++; $display("FAIL clr_done_cycle got=%0d exp=33", done_cyc); end
      checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL busy_at_done got=%b exp=0", busy_at_done); end
      for (int i = 0; i < 32; i++) begin
         rs = 5'(i);
         #1;
         if (rd1 !== 32'h0) nz++;
      end
      checks++; if (nz != 0) begin errors++; $display("FAIL clear_nonzero_entries got=%0d exp=0", nz); end
      rs = 5'd9;
      #1;
      checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL write_during_busy_r9 got=%h exp=%h", rd1, 32'h0); end
   endtask

   task automatic test_reset_mid_clear();
      int nz = 0;
      int late_done = 0;
      int wait_cyc = 0;
      logic seen = 1'b0;
      fill_all();
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (9) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", clr_busy); end
      checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", clr_done); end
      for (int c = 0; c < 30; c++) begin
         if (clr_done !== 1'b0 || clr_busy !== 1'b0) late_done++;
         step();
      end
      checks++; if (late_done != 0) begin errors++; $display("FAIL midrst_activity got=%0d exp=0", late_done); end
      for (int i = 0; i < 32; i++) begin
         rs = 5'(i);
         #1;
         if (rd1 !== 32'h0) nz++;
      end
      checks++; if (nz != 0) begin errors++; $display("FAIL midrst_nonzero_entries got=%0d exp=0", nz); end
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      #1;
      checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL reclear_busy got=%b exp=1", clr_busy); end
      while (!seen && wait_cyc < 50) begin
         step();
         wait_cyc++;
         if (clr_done === 1'b1) seen = 1'b1;
      end
      checks++; if (!seen || wait_cyc != 32) begin errors++; $display("FAIL reclear_done seen=%b cycles=%0d exp_cycles=32", seen, wait_cyc); end
   endtask

   initial begin
      rst           = 1'b0;
      rs            = '0;
      rt            = '0;
      reg_write     = 1'b0;
      reg_to_write  = '0;
      data_to_write = '0;
      clr_req       = 1'b0;
      step();
      test_reset();
      test_write_read();
      test_bypass();
      test_bulk_clear();
      test_reset_mid_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised register file for the single-cycle/multi-cycle datapath: two combinational read ports, one synchronous write port, an optional hardwired zero register and a handshaked bulk-clear sequencer. It replaces the fixed 32x32 bank between instruction decode (rs/rt) and write-back, adding width/depth generics. A clear engine lets the control unit wipe the bank without asserting global reset.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, 1: entry 0 always reads 0 and ignores writes; 0: entry 0 is ordinary storage

- clk  in  1  rising-edge clock; the only clock
- rst  in  1  reset, synchronous, active-high
- rs  in  ADDR_W  read address, port 1
- rt  in  ADDR_W  read address, port 2
- rd1  out  DATA_W  read data, port 1
- rd2  out  DATA_W  read data, port 2
- reg_write  in  1  write enable
- reg_to_write  in  ADDR_W  write address
- data_to_write  in  DATA_W  write data
- clr_req  in  1  bulk-clear request, sampled in IDLE only
- clr_busy  out  1  clear sequence in progress
- clr_done  out  1  one-cycle pulse, clear complete

## Operation
- Write: on rising clk, if reg_write && !clr_busy && !(ZERO_REG && reg_to_write==0), entry[reg_to_write] <= data_to_write.
- Write while clr_busy: dropped silently; no queuing.
- Read: rd1 = entry[rs], rd2 = entry[rt], combinational; address 0 returns 0 when ZERO_REG=1 regardless of storage.
- Same address on rs and rt: both ports return identical data.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 -> CLEAR, ptr <= 0.
  - CLEAR: each cycle entry[ptr] <= 0, ptr <= ptr+1; when ptr==DEPTH-1 -> DONE.
  - DONE: -> IDLE unconditionally.
- clr_req in CLEAR or DONE: ignored; must be re-asserted in IDLE to start another pass.
- Reads during CLEAR return the current mix of cleared and uncleared entries.
- ptr is ADDR_W bits; terminal compare at DEPTH-1, no wrap.

## Timing
- rst (sync): all entries 0, state IDLE, ptr 0, clr_busy 0, clr_done 0; rd1/rd2 = 0 on the cycle after the reset edge. rst dominates every other input, including mid-clear (FSM aborts to IDLE, no clr_done pulse).
- Write latency: data visible on rd1/rd2 in the cycle after the write edge (unless bypass, see Configuration).
- Read latency: 0 cycles (combinational from rs/rt and storage).
- clr_req high in IDLE at edge T -> clr_busy=1 from T+1 through T+DEPTH; entry k cleared at edge T+1+k; clr_done=1 for cycle T+DEPTH+1 only; clr_busy=0 in that cycle.
- Total clear occupancy: DEPTH+1 cycles from request edge to return to IDLE.
- clr_busy and clr_done are decoded from registered state; no combinational path from clr_req.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding; if reg_write && !clr_busy && address writable && reg_to_write==rs, rd1 = data_to_write in the same cycle (likewise rt/rd2). Zero register never forwarded.
- Not defined: no forwarding; rd1/rd2 reflect storage only, new data appears the cycle after the write edge.

## Structure
- Package regfile_pkg: clear FSM state enum (IDLE, CLEAR, DONE), default DATA_W/ADDR_W constants.
- Sub-module regfile_clear_fsm: state register, ptr counter, clr_busy/clr_done decode, outputs clear write enable and address to the bank.
- Storage array, write mux (external vs clear engine), read/bypass logic in the top module.

## Test plan
- Reset then read: rst 1 cycle, rs=5, rt=31 -> rd1=0, rd2=0; clr_busy=0, clr_done=0.
- Write/read: write 0xDEADBEEF to r7, next cycle rs=7 -> rd1=0xDEADBEEF; write 0x1234 to r0 (ZERO_REG=1), rs=0 -> rd1=0.
- Bypass: same cycle reg_write=1, reg_to_write=3, data=0xA5A5A5A5, rs=3 -> rd1=0xA5A5A5A5 with REGFILE_BYPASS_EN, old value (0) without.
- Bulk clear (ADDR_W=5): fill all 32 entries with index+1, pulse clr_req -> clr_busy high exactly 32 cycles, clr_done one pulse at cycle 33, all reads 0; writes during busy dropped (r9 remains 0).
- Reset mid-clear: clr_req, rst at cycle 10 of CLEAR -> clr_busy=0 next cycle, no clr_done pulse, all entries 0, new clr_req accepted normally.
